// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared types and constants for the phase clock generator
// Purpose: FSM state encoding, divisor floor and dead-time legality check.
// Ports: none (package).
package clk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PH1     = 3'd1,
        DEAD1   = 3'd2,
        PH2     = 3'd3,
        DEAD2   = 3'd4,
        STOPPED = 3'd5
    } clk_state_t;

    localparam int CLK_DIV_MIN  = 2;
    localparam int CLK_DEAD_MIN = 1;
    localparam int CLK_DEAD_MAX = 3;

    // Used at elaboration to reject unsupported dead-time settings.
    function automatic bit dead_legal(int dead);
        return (dead >= CLK_DEAD_MIN) && (dead <= CLK_DEAD_MAX);
    endfunction

endpackage

// File: rtl/clock_phase_gen_if.sv
// rtl/clock_phase_gen_if.sv - control/status bundle of the phase clock generator
// Purpose: groups divisor/stop inputs and the latch-drive outputs.
// Ports (signals):
//   Divisor  [DIV_W] phase length request, StopReq halt request,
//   StopAck halted, SetN/RstN active-low latch strobes,
//   Ph1En/Ph2En phase enables, Tick first-cycle-of-Ph1 pulse.
// Modports: master = controller side, slave = generator side.
interface clock_phase_gen_if #(
    parameter int DIV_W = 4
) ();

    logic [DIV_W-1:0] Divisor;
    logic             StopReq;
    logic             StopAck;
    logic             SetN;
    logic             RstN;
    logic             Ph1En;
    logic             Ph2En;
    logic             Tick;

    modport master (
        output Divisor, StopReq,
        input  StopAck, SetN, RstN, Ph1En, Ph2En, Tick
    );

    modport slave (
        input  Divisor, StopReq,
        output StopAck, SetN, RstN, Ph1En, Ph2En, Tick
    );

endinterface

// File: rtl/phase_down_counter.sv
// rtl/phase_down_counter.sv - loadable saturating down-counter
// Purpose: times phase and dead intervals; never wraps below zero.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   load_i            load load_val_i this cycle (wins over dec_i)
//   load_val_i[DIV_W] value to load
//   dec_i             decrement by one, holding at zero
//   count_o[DIV_W]    current count
//   zero_o            count is zero
module phase_down_counter #(
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [DIV_W-1:0] count_o,
    output logic             zero_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/clock_phase_gen.sv
// rtl/clock_phase_gen.sv - two-phase non-overlapping clock enable generator
// Purpose: drives the set/reset side of the phase-clock SR latches with
//   Ph1/Ph2 enables, one-cycle active-low strobes and a stop handshake.
// Ports:
//   MasterClock  sole clock
//   Reset        asynchronous active-high reset
//   bus          clock_phase_gen_if.slave (Divisor, StopReq in; StopAck,
//                SetN, RstN, Ph1En, Ph2En, Tick out)
module clock_phase_gen
    import clk_pkg::*;
#(
    parameter int DIV_W = 4,
    parameter int DEAD  = 1
) (
    input  logic              MasterClock,
    input  logic              Reset,
    clock_phase_gen_if.slave  bus
);

    if (!dead_legal(DEAD)) begin : g_dead_check
        $error("clock_phase_gen: DEAD must be in 1..3");
    end

    localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(CLK_DIV_MIN);
    localparam logic [DIV_W-1:0] DEAD_LOAD = DIV_W'(DEAD - 1);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    clk_state_t       state_q;
    clk_state_t       state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_clamped;

    logic             cnt_load;
    logic [DIV_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [DIV_W-1:0] cnt_count;
    logic             cnt_zero;
    logic             phase_first;

    logic ph1_en_q;
    logic ph2_en_q;
    logic set_n_q;
    logic rst_n_q;
    logic tick_q;
    logic stop_ack_q;

    phase_down_counter #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .clk_i      (MasterClock),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_count),
        .zero_o     (cnt_zero)
    );

    assign div_clamped = (bus.Divisor < DIV_MIN_V) ? DIV_MIN_V : bus.Divisor;

    // Each phase loads div_q-1, so the first cycle of a phase is the one
    // where the counter still holds its load value.
    assign phase_first = (cnt_count == (div_q - ONE));

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d      = PH1;
                div_d        = div_clamped;
                cnt_load     = 1'b1;
                cnt_load_val = div_clamped - ONE;
            end
            PH1: begin
                if (cnt_zero) begin
                    state_d      = DEAD1;
                    cnt_load     = 1'b1;
                    cnt_load_val = DEAD_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DEAD1: begin
                if (cnt_zero) begin
                    state_d      = PH2;
                    cnt_load     = 1'b1;
                    cnt_load_val = div_q - ONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            PH2: begin
                if (cnt_zero) begin
                    state_d      = DEAD2;
                    cnt_load     = 1'b1;
                    cnt_load_val = DEAD_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DEAD2: begin
                // Full-cycle boundary: the only place a stop is honoured.
                if (cnt_zero) begin
                    if (bus.StopReq) begin
                        state_d = STOPPED;
                    end else begin
                        state_d      = PH1;
                        div_d        = div_clamped;
                        cnt_load     = 1'b1;
                        cnt_load_val = div_clamped - ONE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            STOPPED: begin
                if (!bus.StopReq) begin
                    state_d      = PH1;
                    div_d        = div_clamped;
                    cnt_load     = 1'b1;
                    cnt_load_val = div_clamped - ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are a registered decode of the current state, so they trail
    // the state register by one edge and IDLE is visible for one cycle.
    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            div_q      <= DIV_MIN_V;
            ph1_en_q   <= 1'b0;
            ph2_en_q   <= 1'b0;
            set_n_q    <= 1'b1;
            rst_n_q    <= 1'b1;
            tick_q     <= 1'b0;
            stop_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ph1_en_q   <= (state_q == PH1);
            ph2_en_q   <= (state_q == PH2);
            set_n_q    <= !((state_q == PH1) && phase_first);
            tick_q     <= (state_q == PH1) && phase_first;
            rst_n_q    <= !((state_q == PH2) && phase_first);
            stop_ack_q <= (state_q == STOPPED);
        end
    end

    assign bus.Ph1En   = ph1_en_q;
    assign bus.Ph2En   = ph2_en_q;
    assign bus.SetN    = set_n_q;
    assign bus.RstN    = rst_n_q;
    assign bus.Tick    = tick_q;
    assign bus.StopAck = stop_ack_q;

    a_phase_excl: assert property (@(posedge MasterClock) disable iff (Reset)
        !(ph1_en_q && ph2_en_q));
    a_strobe_excl: assert property (@(posedge MasterClock) disable iff (Reset)
        !(!set_n_q && !rst_n_q));
    a_set_in_ph1: assert property (@(posedge MasterClock) disable iff (Reset)
        !set_n_q |-> ph1_en_q);
    a_rst_in_ph2: assert property (@(posedge MasterClock) disable iff (Reset)
        !rst_n_q |-> ph2_en_q);

endmodule
